ysyx_mem_arbiter: RTL and testbench

Two-master scheduler that shares the single D-stage request/response memory port between the I-Cache refill path and the LSU.
- I-Cache side: multi-beat bursts, split by this block into single-beat requests.
- LSU side: single loads and stores.
- Sits between the pipeline core/ICache and the ysyxSoC D-stage IFU/LSU port.
- One transaction outstanding at a time; LSU has priority, bounded by a starvation limit for the IFU.

---
 rtl/ysyx_memarb_pkg.sv | 30 +++
 rtl/ysyx_memarb_burst_seq.sv | 53 +++++
 rtl/ysyx_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_memarb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_memarb_pkg
// Purpose  : Shared types and constants for the D-stage memory arbiter.
//            Holds the arbiter state encoding, the fixed IFU beat size and
//            a saturating-increment helper for the optional perf counters
//            (enabled by YSYX_MEMARB_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_memarb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    LSU_REQ  = 3'd3,
    LSU_WAIT = 3'd4
  } arb_state_t;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam int         BEAT_BYTES    = 4;
  localparam int         BEAT_SHIFT    = $clog2(BEAT_BYTES);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_memarb_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_memarb_burst_seq
// Purpose  : Splits an IFU burst into single-beat addresses. Latches the
//            burst base and length on grant and counts beats.
// Ports    : clk, rst_n     - clock, async active-low reset
//            load           - latch base_in/len_in, restart beat count
//            advance        - move to the next beat
//            base_in/len_in - burst base address / beats minus one
//            beat_addr      - address of the current beat (wraps)
//            last           - current beat is the final one
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_memarb_burst_seq
  import ysyx_memarb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              last
);

  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
      len  <= '0;
      beat <= '0;
    end else if (load) begin
      base <= base_in;
      len  <= len_in;
      beat <= '0;
    end else if (advance) begin
      beat <= beat + LEN_W'(1);
    end
  end

  // Addition is ADDR_W wide, so bursts crossing the top of memory wrap.
  assign beat_addr = base + (ADDR_W'(beat) << BEAT_SHIFT);
  assign last      = (beat == len);

endmodule
`default_nettype wire

// File: rtl/ysyx_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_mem_arbiter
// Purpose  : Shares one D-stage request/response memory port between the
//            I-Cache refill path (bursts, split into beats) and the LSU
//            (single loads/stores). One transaction in flight; LSU wins
//            ties unless the IFU has been passed STARVE_LIMIT times.
// Ports    : ifu_*  - burst request in, per-beat data/last out
//            lsu_*  - single request in, completion/load data out
//            mem_*  - D-stage port: request pulse + fields out, response in
//            perf_* - saturating event counters (only with
//                     YSYX_MEMARB_PERF_EN defined)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_mem_arbiter
  import ysyx_memarb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_i,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  input  logic [LEN_W-1:0]  ifu_len_i,
  output logic              ifu_rvalid_o,
  output logic [31:0]       ifu_rdata_o,
  output logic              ifu_rlast_o,
  input  logic              lsu_req_i,
  input  logic              lsu_wen_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [1:0]        lsu_size_i,
  input  logic [31:0]       lsu_wdata_i,
  input  logic [3:0]        lsu_wmask_i,
  output logic              lsu_rvalid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_reqValid_o,
  output logic [1:0]        mem_size_o,
  output logic              mem_wen_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_respValid_i
`ifdef YSYX_MEMARB_PERF_EN
  ,
  output logic [31:0]       perf_ifu_beats_o,
  output logic [31:0]       perf_lsu_rd_o,
  output logic [31:0]       perf_lsu_wr_o,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_spurious_o
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        state, next_state;
  logic [SW-1:0]     starve_cnt;
  logic              grant_ifu, grant_lsu, beat_adv;
  logic              lsu_wen_q;
  logic [ADDR_W-1:0] lsu_addr_q;
  logic [1:0]        lsu_size_q;
  logic [31:0]       lsu_wdata_q;
  logic [3:0]        lsu_wmask_q;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;

  ysyx_memarb_burst_seq #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant_ifu),
    .advance   (beat_adv),
    .base_in   (ifu_addr_i),
    .len_in    (ifu_len_i),
    .beat_addr (beat_addr),
    .last      (beat_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      lsu_wen_q   <= 1'b0;
      lsu_addr_q  <= '0;
      lsu_size_q  <= '0;
      lsu_wdata_q <= '0;
      lsu_wmask_q <= '0;
    end else begin
      state <= next_state;
      if (grant_ifu) begin
        starve_cnt <= '0;
      end else if (grant_lsu && ifu_req_i && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      if (grant_lsu) begin
        lsu_wen_q   <= lsu_wen_i;
        lsu_addr_q  <= lsu_addr_i;
        lsu_size_q  <= lsu_size_i;
        lsu_wdata_q <= lsu_wdata_i;
        lsu_wmask_q <= lsu_wmask_i;
      end
    end
  end

  always_comb begin
    next_state     = state;
    grant_ifu      = 1'b0;
    grant_lsu      = 1'b0;
    beat_adv       = 1'b0;
    mem_reqValid_o = 1'b0;
    mem_addr_o     = '0;
    mem_size_o     = '0;
    mem_wen_o      = 1'b0;
    mem_wdata_o    = '0;
    mem_wmask_o    = '0;
    ifu_rvalid_o   = 1'b0;
    ifu_rdata_o    = '0;
    ifu_rlast_o    = 1'b0;
    lsu_rvalid_o   = 1'b0;
    lsu_rdata_o    = '0;
    unique case (state)
      IDLE: begin
        if (lsu_req_i && !(ifu_req_i && starve_cnt == STARVE_MAX)) begin
          grant_lsu  = 1'b1;
          next_state = LSU_REQ;
        end else if (ifu_req_i) begin
          grant_ifu  = 1'b1;
          next_state = IFU_REQ;
        end
      end
      IFU_REQ: begin
        mem_addr_o = beat_addr;
        mem_size_o = MEM_SIZE_WORD;
        // A withdrawn burst issues nothing more; nothing is outstanding yet.
        if (ifu_req_i) begin
          mem_reqValid_o = 1'b1;
          next_state     = IFU_WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      IFU_WAIT: begin
        mem_addr_o = beat_addr;
        mem_size_o = MEM_SIZE_WORD;
        if (mem_respValid_i) begin
          if (!ifu_req_i) begin
            // Abort: swallow the beat that was already in flight.
            next_state = IDLE;
          end else begin
            ifu_rvalid_o = 1'b1;
            ifu_rdata_o  = mem_rdata_i;
            if (beat_last) begin
              ifu_rlast_o = 1'b1;
              next_state  = IDLE;
            end else begin
              beat_adv   = 1'b1;
              next_state = IFU_REQ;
            end
          end
        end
      end
      LSU_REQ, LSU_WAIT: begin
        mem_addr_o  = lsu_addr_q;
        mem_size_o  = lsu_size_q;
        mem_wen_o   = lsu_wen_q;
        mem_wdata_o = lsu_wdata_q;
        mem_wmask_o = lsu_wmask_q;
        if (state == LSU_REQ) begin
          mem_reqValid_o = 1'b1;
          next_state     = LSU_WAIT;
        end else if (mem_respValid_i) begin
          lsu_rvalid_o = 1'b1;
          lsu_rdata_o  = mem_rdata_i;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef YSYX_MEMARB_PERF_EN
  logic any_req, in_wait;
  assign any_req = ifu_req_i | lsu_req_i;
  assign in_wait = (state == IFU_WAIT) || (state == LSU_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ifu_beats_o <= '0;
      perf_lsu_rd_o    <= '0;
      perf_lsu_wr_o    <= '0;
      perf_stall_o     <= '0;
      perf_spurious_o  <= '0;
    end else begin
      if (ifu_rvalid_o)              perf_ifu_beats_o <= sat_inc(perf_ifu_beats_o);
      if (lsu_rvalid_o && !lsu_wen_q) perf_lsu_rd_o   <= sat_inc(perf_lsu_rd_o);
      if (lsu_rvalid_o && lsu_wen_q)  perf_lsu_wr_o   <= sat_inc(perf_lsu_wr_o);
      // A requester waits whenever the port is busy, or it loses an IDLE tie.
      if (any_req && (state != IDLE || (ifu_req_i && lsu_req_i)))
        perf_stall_o <= sat_inc(perf_stall_o);
      if (mem_respValid_i && !in_wait) perf_spurious_o <= sat_inc(perf_spurious_o);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_mem_arbiter
// Purpose  : Self-checking bench for ysyx_mem_arbiter. Directed scenarios
//            followed by a randomized phase, all compared cycle by cycle
//            against a transaction-timing reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req, ifu_rvalid, ifu_rlast, lsu_req, lsu_wen, lsu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata, lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  ifu_len;
  logic [1:0]  lsu_size, mem_size;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_reqValid, mem_wen, mem_respValid;
`ifdef YSYX_MEMARB_PERF_EN
  logic [31:0] perf_ifu_beats, perf_lsu_rd, perf_lsu_wr, perf_stall, perf_spurious;
`endif

  ysyx_mem_arbiter #(.ADDR_W(32), .LEN_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_len_i(ifu_len),
    .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata), .ifu_rlast_o(ifu_rlast),
    .lsu_req_i(lsu_req), .lsu_wen_i(lsu_wen), .lsu_addr_i(lsu_addr),
    .lsu_size_i(lsu_size), .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .mem_addr_o(mem_addr), .mem_reqValid_o(mem_reqValid), .mem_size_o(mem_size),
    .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rdata_i(mem_rdata), .mem_respValid_i(mem_respValid)
`ifdef YSYX_MEMARB_PERF_EN
    , .perf_ifu_beats_o(perf_ifu_beats), .perf_lsu_rd_o(perf_lsu_rd),
    .perf_lsu_wr_o(perf_lsu_wr), .perf_stall_o(perf_stall),
    .perf_spurious_o(perf_spurious)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;

  // Requester agents (applied to the DUT just after each rising edge)
  logic        a_ifu_req = 0, a_lsu_req = 0, a_lsu_wen = 0;
  logic [31:0] a_ifu_addr = 0, a_lsu_addr = 0, a_lsu_wdata = 0;
  logic [7:0]  a_ifu_len = 0;
  logic [1:0]  a_lsu_size = 0;
  logic [3:0]  a_lsu_wmask = 0;
  int          lsu_backlog = 0, store_k = 0;
  bit          rnd = 0;
  // Memory responder
  int          resp_at = -1, fixed_lat = 0;
  logic [31:0] resp_data = 0;
  // Observation logs
  logic [31:0] pulse_log[$];
  int          n_irv = 0, n_rlast = 0, n_lrv = 0;

  // Reference model: who owns the port and when the next events are due
  int          m_owner;           // 0 none, 1 IFU, 2 LSU
  bit          m_pend;
  int          m_pulse_at, m_arb_at, m_starve, m_beat;
  logic [31:0] m_base, m_laddr, m_lwdata;
  int          m_len;
  logic        m_lwen;
  logic [1:0]  m_lsize;
  logic [3:0]  m_lwmask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_pend = 0; m_pulse_at = -1; m_starve = 0; m_beat = 0;
    m_arb_at = cyc + 1;
  endtask

  task automatic model_step();
    bit ep, eirv, elrv, elast;
    ep = (cyc == m_pulse_at); eirv = 0; elrv = 0; elast = 0;
    if (ep && m_owner == 1 && !ifu_req) begin
      ep = 0; m_owner = 0; m_arb_at = cyc + 1;
    end
    if (ep) begin
      m_pend = 1;
      if (m_owner == 1) begin
        check("ifu_beat_addr", mem_addr, m_base + 32'(m_beat * 4));
        check("ifu_beat_size", 32'(mem_size), 32'd2);
        check("ifu_beat_wen", 32'(mem_wen), 32'd0);
      end else begin
        check("lsu_addr", mem_addr, m_laddr);
        check("lsu_wen", 32'(mem_wen), 32'(m_lwen));
        check("lsu_size", 32'(mem_size), 32'(m_lsize));
        check("lsu_wdata", mem_wdata, m_lwdata);
        check("lsu_wmask", 32'(mem_wmask), 32'(m_lwmask));
      end
    end
    if (mem_respValid && m_pend && cyc > m_pulse_at) begin
      m_pend = 0;
      if (m_owner == 1 && ifu_req) begin
        eirv = 1; elast = (m_beat == m_len);
        check("ifu_rdata", ifu_rdata, resp_data);
        if (elast) begin m_owner = 0; m_arb_at = cyc + 1; end
        else begin m_beat++; m_pulse_at = cyc + 1; end
      end else if (m_owner == 1) begin
        m_owner = 0; m_arb_at = cyc + 1;
      end else begin
        elrv = 1;
        check("lsu_rdata", lsu_rdata, resp_data);
        m_owner = 0; m_arb_at = cyc + 1;
      end
    end
    if (rst_n && m_owner == 0 && cyc >= m_arb_at && (lsu_req || ifu_req)) begin
      if (lsu_req && !(ifu_req && m_starve == LIMIT)) begin
        m_owner = 2;
        if (ifu_req && m_starve < LIMIT) m_starve++;
        m_laddr = lsu_addr; m_lwen = lsu_wen; m_lsize = lsu_size;
        m_lwdata = lsu_wdata; m_lwmask = lsu_wmask;
      end else begin
        m_owner = 1; m_starve = 0; m_base = ifu_addr; m_len = int'(ifu_len); m_beat = 0;
      end
      m_pulse_at = cyc + 1;
    end
    check("mem_reqValid", 32'(mem_reqValid), 32'(ep));
    check("ifu_rvalid", 32'(ifu_rvalid), 32'(eirv));
    check("ifu_rlast", 32'(ifu_rlast), 32'(elast));
    check("lsu_rvalid", 32'(lsu_rvalid), 32'(elrv));
  endtask

  task automatic new_lsu();
    a_lsu_req = 1; a_lsu_wen = 1'($urandom_range(0, 1)); a_lsu_addr = $urandom;
    a_lsu_size = 2'($urandom_range(0, 2)); a_lsu_wdata = $urandom;
    a_lsu_wmask = 4'($urandom_range(0, 15));
  endtask

  task automatic new_ifu();
    logic [31:0] t;
    t = $urandom;
    a_ifu_req = 1;
    a_ifu_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : (t & 32'hFFFF_FFFC);
    a_ifu_len = 8'($urandom_range(0, 3));
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    ifu_req = a_ifu_req; ifu_addr = a_ifu_addr; ifu_len = a_ifu_len;
    lsu_req = a_lsu_req; lsu_wen = a_lsu_wen; lsu_addr = a_lsu_addr;
    lsu_size = a_lsu_size; lsu_wdata = a_lsu_wdata; lsu_wmask = a_lsu_wmask;
    mem_respValid = (cyc == resp_at);
    mem_rdata = mem_respValid ? resp_data : $urandom;
    @(negedge clk);
    model_step();
    if (mem_reqValid) pulse_log.push_back(mem_addr);
    if (ifu_rvalid) n_irv++;
    if (ifu_rlast) begin n_rlast++; a_ifu_req = 0; end
    if (lsu_rvalid) begin
      n_lrv++;
      if (lsu_backlog > 0) begin
        lsu_backlog--; store_k++;
        a_lsu_addr = 32'h9000_0000 + 32'(store_k * 4); a_lsu_wdata = $urandom;
      end else a_lsu_req = 0;
    end
    if (mem_reqValid) begin
      resp_at = cyc + 1 + (rnd ? int'($urandom_range(0, 3)) : fixed_lat);
      resp_data = $urandom;
    end
    if (rnd) begin
      if (!a_lsu_req && $urandom_range(0, 3) == 0) new_lsu();
      if (!a_ifu_req && $urandom_range(0, 5) == 0) new_ifu();
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((a_lsu_req || a_ifu_req || m_owner != 0) && n < max_cyc) begin
      tick(); n++;
    end
    check("idle_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic do_reset();
    a_ifu_req = 0; a_lsu_req = 0; resp_at = -1;
    rst_n = 0; model_reset();
    tick(); tick();
    rst_n = 1; model_reset();
  endtask

  initial begin
    int base_lrv;
    rst_n = 0; ifu_req = 0; ifu_addr = 0; ifu_len = 0; lsu_req = 0; lsu_wen = 0;
    lsu_addr = 0; lsu_size = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_rdata = 32'hDEAD_BEEF; mem_respValid = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_reqValid", 32'(mem_reqValid), 32'd0);
    check("rst_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
    check("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_size", 32'(mem_size), 32'd0);
    rst_n = 1; model_reset();

    // 1: lone IFU burst, four beats at consecutive words
    pulse_log.delete(); n_irv = 0; n_rlast = 0;
    a_ifu_req = 1; a_ifu_addr = 32'h3000_0000; a_ifu_len = 8'd3; fixed_lat = 1;
    wait_idle(100);
    check("t1_pulses", pulse_log.size(), 4);
    for (int i = 0; i < 4 && i < pulse_log.size(); i++)
      check("t1_addr", pulse_log[i], 32'h3000_0000 + 32'(i * 4));
    check("t1_beats", n_irv, 4);
    check("t1_rlast", n_rlast, 1);

    // 2: simultaneous LSU load and IFU burst, LSU first
    pulse_log.delete(); fixed_lat = 0;
    a_lsu_req = 1; a_lsu_wen = 0; a_lsu_addr = 32'h8000_0010; a_lsu_size = 2'b10;
    a_lsu_wdata = 0; a_lsu_wmask = 0;
    a_ifu_req = 1; a_ifu_addr = 32'h3000_0100; a_ifu_len = 8'd1;
    wait_idle(100);
    check("t2_pulses", pulse_log.size(), 3);
    if (pulse_log.size() >= 2) begin
      check("t2_first", pulse_log[0], 32'h8000_0010);
      check("t2_second", pulse_log[1], 32'h3000_0100);
    end

    // 3: five back-to-back stores against a waiting IFU
    pulse_log.delete(); store_k = 0; lsu_backlog = 4;
    a_lsu_req = 1; a_lsu_wen = 1; a_lsu_addr = 32'h9000_0000; a_lsu_size = 2'b10;
    a_lsu_wdata = 32'h1111_2222; a_lsu_wmask = 4'hF;
    a_ifu_req = 1; a_ifu_addr = 32'h3000_0200; a_ifu_len = 8'd0;
    wait_idle(200);
    check("t3_pulses", pulse_log.size(), 6);
    if (pulse_log.size() >= 6) begin
      check("t3_fourth_lsu", pulse_log[3], 32'h9000_000C);
      check("t3_ifu_wins", pulse_log[4], 32'h3000_0200);
      check("t3_fifth_store", pulse_log[5], 32'h9000_0010);
    end

    // 4: IFU withdraws with beat 2 outstanding
    pulse_log.delete(); n_irv = 0; n_rlast = 0; fixed_lat = 1;
    a_ifu_req = 1; a_ifu_addr = 32'h3000_0300; a_ifu_len = 8'd3;
    for (int i = 0; i < 50 && pulse_log.size() < 3; i++) tick();
    a_ifu_req = 0;
    repeat (8) tick();
    check("t4_pulses", pulse_log.size(), 3);
    check("t4_beats", n_irv, 2);
    check("t4_rlast", n_rlast, 0);
    a_lsu_req = 1; a_lsu_wen = 0; a_lsu_addr = 32'h8000_0020;
    wait_idle(50);

    // 5: reset while an LSU load waits for its response
    fixed_lat = 6;
    a_lsu_req = 1; a_lsu_wen = 0; a_lsu_addr = 32'h8000_0040; a_lsu_size = 2'b10;
    tick(); tick(); tick();
    #2 rst_n = 0; #1;
    check("t5_reqValid", 32'(mem_reqValid), 32'd0);
    check("t5_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    check("t5_mem_addr", mem_addr, 32'd0);
    check("t5_mem_size", 32'(mem_size), 32'd0);
    a_lsu_req = 0; model_reset();
    tick(); tick();
    rst_n = 1; model_reset();
    base_lrv = n_lrv;
    for (int i = 0; i < 20 && cyc <= resp_at; i++) tick();
    check("t5_stray_ignored", n_lrv, base_lrv);
    fixed_lat = 0;
    a_lsu_req = 1; a_lsu_wen = 1; a_lsu_addr = 32'h8000_0044; a_lsu_wdata = 32'hCAFE_F00D;
    wait_idle(50);
    check("t5_fresh_served", n_lrv, base_lrv + 1);

    // Randomized traffic
    rnd = 1;
    repeat (600) tick();
    rnd = 0;
    wait_idle(200);

`ifdef YSYX_MEMARB_PERF_EN
    do_reset();
    check("perf_rst_beats", perf_ifu_beats, 32'd0);
    check("perf_rst_spur", perf_spurious, 32'd0);
    a_ifu_req = 1; a_ifu_addr = 32'h3000_0000; a_ifu_len = 8'd3;
    wait_idle(100);
    a_lsu_req = 1; a_lsu_wen = 0; a_lsu_addr = 32'h8000_0000;
    wait_idle(50);
    a_lsu_req = 1; a_lsu_wen = 1; a_lsu_addr = 32'h8000_0004;
    wait_idle(50);
    tick();
    check("perf_beats", perf_ifu_beats, 32'd4);
    check("perf_rd", perf_lsu_rd, 32'd1);
    check("perf_wr", perf_lsu_wr, 32'd1);
    check("perf_spur0", perf_spurious, 32'd0);
    resp_at = cyc + 1; resp_data = 32'h5A5A_5A5A;
    tick(); tick();
    check("perf_spur1", perf_spurious, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
